// File: rtl/uart_tx_main.sv
// UART transmitter: serialises a DBIT-wide word as start / data (LSB first) / stop
// on a 16x oversampling tick derived from the system clock. All outputs are registered.
module uart_tx_main #(
   parameter int DBIT     = 8,
   parameter int SB_TICK  = 16,
   parameter int BAUD_DIV = 651
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            tx_start,
   input  logic [DBIT-1:0] tx_din,
   output logic            tx,
   output logic            tx_busy,
   output logic            tx_done_tick
);

   localparam int BDW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
   localparam int BCW = (DBIT > 2) ? $clog2(DBIT) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t          state_q;
   logic [BDW-1:0]  baud_q;
   logic [BDW-1:0]  baud_d;
   logic [4:0]      tick_q;
   logic [BCW-1:0]  bit_q;
   logic [DBIT-1:0] shreg_q;
   logic            tx_q;
   logic            busy_q;
   logic            done_q;
   logic            s_tick;

   always_comb begin
      s_tick = (baud_q == BDW'(BAUD_DIV - 1));
      baud_d = s_tick ? '0 : baud_q + BDW'(1);
   end

   // Outputs are assigned together with the transition so they line up with state_q.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         tick_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         baud_q <= baud_d;
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
               if (tx_start) begin
                  shreg_q <= tx_din;
                  tick_q  <= '0;
                  baud_q  <= '0;
                  state_q <= S_START;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            S_START: begin
               if (s_tick) begin
                  if (tick_q == 5'd15) begin
                     tick_q  <= '0;
                     bit_q   <= '0;
                     state_q <= S_DATA;
                     tx_q    <= shreg_q[0];
                  end else begin
                     tick_q <= tick_q + 5'd1;
                  end
               end
            end
            S_DATA: begin
               if (s_tick) begin
                  if (tick_q == 5'd15) begin
                     tick_q  <= '0;
                     shreg_q <= shreg_q >> 1;
                     if (bit_q == BCW'(DBIT - 1)) begin
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                     end else begin
                        bit_q <= bit_q + BCW'(1);
                        tx_q  <= shreg_q[1];
                     end
                  end else begin
                     tick_q <= tick_q + 5'd1;
                  end
               end
            end
            S_STOP: begin
               if (s_tick) begin
                  if (tick_q == 5'(SB_TICK - 1)) begin
                     tick_q  <= '0;
                     state_q <= S_IDLE;
                     tx_q    <= 1'b1;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     tick_q <= tick_q + 5'd1;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign tx           = tx_q;
   assign tx_busy      = busy_q;
   assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_main.sv
// Directed bench for uart_tx_main: two instances (1 and 2 stop bits) at BAUD_DIV=4,
// frame vectors from a table plus hand sequences for back-to-back, ignore and abort.
module tb_uart_tx_main;

   localparam int DBIT     = 8;
   localparam int BAUD_DIV = 4;
   localparam int BITCLK   = 16 * BAUD_DIV;
   localparam int DATA_END = (DBIT + 1) * BITCLK;

   logic       clk = 1'b0;
   logic       reset;
   logic       start1, start2;
   logic [7:0] din1, din2;
   logic       tx1, busy1, done1;
   logic       tx2, busy2, done2;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [7:0] din;
      int         sb;
      bit         sel;
   } vec_t;

   vec_t tbl[6];

   uart_tx_main #(.DBIT(DBIT), .SB_TICK(16), .BAUD_DIV(BAUD_DIV)) dut1 (
      .clk(clk), .reset(reset), .tx_start(start1), .tx_din(din1),
      .tx(tx1), .tx_busy(busy1), .tx_done_tick(done1)
   );

   uart_tx_main #(.DBIT(DBIT), .SB_TICK(32), .BAUD_DIV(BAUD_DIV)) dut2 (
      .clk(clk), .reset(reset), .tx_start(start2), .tx_din(din2),
      .tx(tx2), .tx_busy(busy2), .tx_done_tick(done2)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] obs(input bit sel);
      return sel ? {tx2, busy2, done2} : {tx1, busy1, done1};
   endfunction

   task automatic check3(input string name, input logic [2:0] got, input logic [2:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got tx/busy/done=%b required %b", name, got, exp);
      end
   endtask

   // Watch n idle cycles; report the first deviation from tx=1,busy=0,done=0.
   task automatic idle_watch(input string name, input bit sel, input int n);
      logic [2:0] first_bad;
      bit         bad;
      bad       = 1'b0;
      first_bad = 3'b100;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (obs(sel) !== 3'b100 && !bad) begin
            bad       = 1'b1;
            first_bad = obs(sel);
         end
      end
      check3(name, bad ? first_bad : obs(sel), 3'b100);
   endtask

   // Request a frame; on return the accept edge has just passed (cycle 1 of the frame).
   task automatic launch(input bit sel, input logic [7:0] din);
      @(posedge clk); #1;
      if (sel) begin start2 = 1'b1; din2 = din; end
      else     begin start1 = 1'b1; din1 = din; end
      @(negedge clk);
      check3($sformatf("pre_accept_%02h", din), obs(sel), 3'b100);
      @(posedge clk); #1;
      if (sel) begin start2 = 1'b0; din2 = ~din; end
      else     begin start1 = 1'b0; din1 = ~din; end
   endtask

   // Checks one frame cycle by cycle, one comparison per bit period plus the done cycle.
   // poke_k: cycle at which a stray tx_start with data 0 is issued; abort_k: cycle of reset.
   task automatic check_frame(input logic [7:0] din, input int sb, input bit sel,
                              input int poke_k, input int abort_k);
      int         len;
      logic [2:0] exp, got, bad_got, bad_exp;
      bit         bad;
      len     = DATA_END + sb * BAUD_DIV;
      bad     = 1'b0;
      bad_got = '0;
      bad_exp = '0;
      for (int k = 1; k <= len + 1; k++) begin
         if (k > 1) begin
            @(posedge clk); #1;
            if (poke_k != 0 && k == poke_k) begin
               if (sel) begin start2 = 1'b1; din2 = 8'h00; end
               else     begin start1 = 1'b1; din1 = 8'h00; end
            end else if (poke_k != 0 && k == poke_k + 1) begin
               if (sel) start2 = 1'b0;
               else     start1 = 1'b0;
            end
            if (k == abort_k) reset = 1'b1;
         end
         @(negedge clk);
         if (k <= BITCLK)        exp = 3'b010;
         else if (k <= DATA_END) exp = {din[(k - BITCLK - 1) / BITCLK], 2'b10};
         else if (k <= len)      exp = 3'b110;
         else                    exp = 3'b101;
         got = obs(sel);
         if (got !== exp && !bad) begin
            bad     = 1'b1;
            bad_got = got;
            bad_exp = exp;
         end
         if (abort_k != 0 && k == abort_k) begin
            check3($sformatf("pre_abort_%02h", din), bad ? bad_got : got, bad ? bad_exp : exp);
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            check3("abort_next_edge", obs(sel), 3'b100);
            idle_watch("abort_no_done", sel, len + 20);
            return;
         end
         if ((k % BITCLK == 0 && k <= DATA_END) || k == len || k == len + 1) begin
            check3($sformatf("frame_%02h_sb%0d_k%0d", din, sb, k),
                   bad ? bad_got : got, bad ? bad_exp : exp);
            bad = 1'b0;
         end
      end
   endtask

   initial begin
      tbl[0] = '{din: 8'hA5, sb: 16, sel: 1'b0};
      tbl[1] = '{din: 8'h00, sb: 16, sel: 1'b0};
      tbl[2] = '{din: 8'hFF, sb: 16, sel: 1'b0};
      tbl[3] = '{din: 8'h01, sb: 32, sel: 1'b1};
      tbl[4] = '{din: 8'h80, sb: 32, sel: 1'b1};
      tbl[5] = '{din: 8'h96, sb: 16, sel: 1'b0};

      reset  = 1'b1;
      start1 = 1'b0;
      start2 = 1'b0;
      din1   = 8'h00;
      din2   = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check3("reset_dut1", obs(1'b0), 3'b100);
      check3("reset_dut2", obs(1'b1), 3'b100);
      @(posedge clk); #1;
      reset = 1'b0;
      idle_watch("idle100_dut1", 1'b0, 100);
      check3("idle100_dut2", obs(1'b1), 3'b100);

      for (int i = 0; i < 6; i++) begin
         launch(tbl[i].sel, tbl[i].din);
         check_frame(tbl[i].din, tbl[i].sb, tbl[i].sel, 0, 0);
      end

      // tx_start held high: data changes after acceptance; second frame starts right after done.
      @(posedge clk); #1;
      start1 = 1'b1;
      din1   = 8'h3C;
      @(posedge clk); #1;
      din1 = 8'hFF;
      check_frame(8'h3C, 16, 1'b0, 0, 0);
      @(posedge clk); #1;
      start1 = 1'b0;
      check_frame(8'hFF, 16, 1'b0, 0, 0);
      idle_watch("after_b2b", 1'b0, 10);

      // Stray request during data bits is ignored.
      launch(1'b0, 8'hA5);
      check_frame(8'hA5, 16, 1'b0, 200, 0);
      idle_watch("after_poke", 1'b0, 40);

      // Reset during data bit 3, then a clean frame.
      launch(1'b0, 8'hC3);
      check_frame(8'hC3, 16, 1'b0, 0, BITCLK + 3 * BITCLK + 20);
      launch(1'b0, 8'h55);
      check_frame(8'h55, 16, 1'b0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_main.md
Name: uart_tx_main

Overview:
UART transmitter and the transmit-side partner of the team's 16x-oversampling UART receiver. It serialises a DBIT-wide word into an 8N1-style frame (start bit, data LSB-first, stop) on a single line. The block generates its own oversampling tick from the system clock. It exposes a start/busy/done handshake toward the user logic that loads bytes.

Parameters:
DBIT, 8, number of data bits per frame (2..16)
SB_TICK, 16, stop-bit duration in oversampling ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2)
BAUD_DIV, 651, clk cycles per oversampling tick (651 gives 9600 baud x16 at 100 MHz); must be >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
tx_start  input  1  request to send tx_din; sampled only in idle
tx_din  input  DBIT  word to transmit; latched on accepted tx_start
tx  output  1  serial line, idles high
tx_busy  output  1  high from the cycle after acceptance until frame end
tx_done_tick  output  1  one-clk pulse at end of stop bit

Behaviour:
- Reset (sampled on clk edge): state=idle, tx=1, tx_busy=0, tx_done_tick=0, baud counter=0, tick counter=0, bit counter=0, shift register=0. Reset mid-frame aborts immediately: tx returns high on the next edge, with no done pulse.
- Baud generator: counter 0..BAUD_DIV-1. s_tick is high for one clk when counter==BAUD_DIV-1, then the counter wraps to 0.
  - The counter is forced to 0 on the cycle tx_start is accepted, so every bit is exactly 16*BAUD_DIV clks long (stop bit SB_TICK*BAUD_DIV).
- All outputs are registered.
- States:
  - idle: tx=1, tx_busy=0. If tx_start=1, latch tx_din into the shift register, clear the tick counter, go to start.
  - start: tx=0. On each s_tick, increment the tick counter. On the s_tick where it equals 15, clear it, clear the bit counter, go to data.
  - data: tx = shift register bit 0. On the s_tick where the tick counter equals 15: clear it and shift right by one. If bit counter==DBIT-1, go to stop; else increment the bit counter.
  - stop: tx=1. On the s_tick where the tick counter equals SB_TICK-1: go to idle and pulse tx_done_tick.
- Registered outputs take their values in the cycle state_reg holds the new state.
  - tx falls one clk after the tx_start cycle.
  - tx_busy=1 in start/data/stop.
  - tx_done_tick=1 in exactly the first idle cycle after stop, with tx_busy=0 in that same cycle.
- tx_start is accepted in the same cycle tx_done_tick is high (back-to-back frames; only the 1-clk idle gap between stop and the next start).
- tx_start while tx_busy=1 is ignored: no queueing, and the in-flight frame is unaffected. A tx_din change after acceptance has no effect.
- Frame length from acceptance to tx_done_tick = (16*(DBIT+1)+SB_TICK)*BAUD_DIV clks.
- Tick counter width: 5 bits (covers SB_TICK up to 32). Bit counter width: $clog2(DBIT).
- Illegal state encodings return to idle with tx=1.

Test Plan:
- Reset, then hold idle for 100 clks -> tx=1, tx_busy=0, tx_done_tick=0 throughout.
- BAUD_DIV=4, DBIT=8, SB_TICK=16; pulse tx_start with tx_din=0xA5 ->
  - tx low 1 clk later for 64 clks;
  - then bits 1,0,1,0,0,1,0,1 at 64 clks each;
  - then high for 64 clks;
  - tx_done_tick is a single pulse exactly 640 clks after the tx_start cycle.
- Same config; hold tx_start high continuously with tx_din=0x3C then 0xFF ->
  - two consecutive frames, with the second start bit beginning 1 clk after the first done pulse;
  - a loopback into uart_rx_main (matching tick rate) recovers 0x3C and 0xFF.
- Mid-frame, assert tx_start with tx_din=0x00 during data -> ignored; the original byte completes unchanged and exactly one done pulse occurs.
- Assert reset during bit 3 of a frame -> tx=1 and tx_busy=0 on the next edge, no tx_done_tick. A new tx_start=0x55 afterwards produces a clean 640-clk frame.
- SB_TICK=32, tx_din=0x01 -> stop level held 128 clks, frame length 704 clks.
